frame_uart_tx: RTL and testbench
================================

FRAME_UART_TX -- requirements
Module: frame_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clock cycles per UART bit (27 MHz / 115200); legal range 2..65535.
REQ-002 Parameter SEND_FAILED, default 1; 1 transmits frames with success=0, 0 drops them silently (clear still pulsed).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 finish  input  1  demodulator frame-ready level; held high until cleared.
REQ-006 success  input  1  demodulator check result; valid while finish=1.
REQ-007 res  input  96  demodulated payload; valid while finish=1.
REQ-008 clear  output  1  one-cycle pulse acknowledging capture, wired to the demodulator's clear.
REQ-009 tx  output  1  UART line, 8N1, idle high.
REQ-010 busy  output  1  high from capture until the last stop bit completes.

Function
REQ-011 Top FSM states: IDLE, SEND, NEXT; the sub-module holds its own bit-level FSM.
REQ-012 IDLE with finish=1 on cycle C: latch res, success; clear=1 and busy=1 on C+1 only for clear; otherwise finish ignored.
REQ-013 If SEND_FAILED=0 and latched success=0: pulse clear at C+1, return to IDLE, busy stays 0, tx stays 1.
REQ-014 Frame = 14 bytes in order: 0xA5 header, status byte (0x01 if success else 0x00), then res[95:88], res[87:80], ... res[7:0].
REQ-015 Each byte: start bit 0, data bits LSB first, stop bit 1; each bit exactly CLKS_PER_BIT cycles.
REQ-016 Start bit of header begins at C+1 (tx=0 from C+1).
REQ-017 Bytes sent back-to-back; next start bit immediately follows previous stop bit, zero idle cycles.
REQ-018 Frame length exactly 140*CLKS_PER_BIT cycles; busy falls on the cycle tx's final stop bit ends.
REQ-019 finish rising while busy=1: not captured, no clear; serviced on first IDLE cycle after busy falls (finish is a held level).
REQ-020 finish=1 on the same cycle busy falls: not captured that cycle; captured next cycle.
REQ-021 res/success changes after capture do not affect the frame in flight.
REQ-022 Byte index counter 4 bits, saturates at 13, wraps to 0 on return to IDLE; bit-period counter 16 bits, reloads per bit.

Reset
REQ-023 rst=1 at any time, including mid-frame: next cycle tx=1, clear=0, busy=0, FSM IDLE, counters 0, latched data 0.
REQ-024 A frame aborted by reset is not resumed; a still-high finish after reset release is captured as a new frame.

Structure
REQ-025 Shared package holds HEADER_BYTE=8'hA5, STATUS_OK=8'h01, STATUS_NG=8'h00, FRAME_BYTES=14.
REQ-026 One sub-module uart_tx_byte (ports clk, rst, start, data[7:0], tx, done) implements REQ-015; done pulses on the final stop-bit cycle, start accepted on that same cycle for back-to-back bytes.
REQ-027 Top level contains only frame FSM, byte mux and capture registers.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-028 Reset, then finish=1, success=1, res=0x55...55 (all 0x55) -> clear pulse one cycle; tx decodes A5 01 55x12; busy high 560 cycles.
REQ-029 success=0, res=0x55 00..00 55, SEND_FAILED=1 -> bytes A5 00 55 00x10 55; SEND_FAILED=0 -> clear pulse, tx constant 1, busy 0.
REQ-030 Second finish asserted 100 cycles into a frame -> no clear until busy falls; second frame's start bit begins 2 cycles after busy falls (capture + 1).
REQ-031 rst asserted at cycle 300 of a frame -> tx=1, busy=0 next cycle; with finish still high after release, a full new frame starting with A5.
REQ-032 CLKS_PER_BIT=2 and 234 -> every bit width measured exactly 2 / 234 cycles, no gap between stop and next start bit.

Source files
------------

// File: rtl/frame_uart_tx_pkg.sv
// Shared constants, state types and the frame byte selector for the frame UART transmitter.
// The frame is a header, a status byte, then the 96-bit payload sent most-significant byte first.
package frame_uart_tx_pkg;

   localparam logic [7:0] HEADER_BYTE   = 8'hA5;
   localparam logic [7:0] STATUS_OK     = 8'h01;
   localparam logic [7:0] STATUS_NG     = 8'h00;
   localparam int         FRAME_BYTES   = 14;
   localparam logic [3:0] LAST_BYTE_IDX = 4'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_NEXT = 2'd2
   } frame_state_t;

   typedef enum logic [1:0] {
      BIT_IDLE  = 2'd0,
      BIT_START = 2'd1,
      BIT_DATA  = 2'd2,
      BIT_STOP  = 2'd3
   } bit_state_t;

   // Byte 2 carries res[95:88] and byte 13 carries res[7:0]; out-of-range indices give zero.
   function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                             input logic success,
                                             input logic [95:0] res);
      logic [3:0] rev_s;
      logic [7:0] byte_s;
      rev_s = 4'd0;
      case (idx)
         4'd0:    byte_s = HEADER_BYTE;
         4'd1:    byte_s = success ? STATUS_OK : STATUS_NG;
         default: begin
            if (idx <= LAST_BYTE_IDX) begin
               rev_s  = 4'(LAST_BYTE_IDX - idx);
               byte_s = 8'(res >> {rev_s, 3'b000});
            end else begin
               byte_s = 8'h00;
            end
         end
      endcase
      return byte_s;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// done is high on the final stop-bit cycle, and a start on that cycle chains the next byte gaplessly.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 234
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);
   import frame_uart_tx_pkg::*;

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   bit_state_t  state_r, nxt_state_s;
   logic [15:0] cnt_r, nxt_cnt_s;
   logic [2:0]  bit_idx_r, nxt_bit_idx_s;
   logic [7:0]  shift_r, nxt_shift_s;
   logic        tx_r, nxt_tx_s;
   logic        done_r, nxt_done_s;
   logic        bit_end_s;

   assign bit_end_s = (cnt_r == LAST_CNT);

   // Bit-level next-state, counter reload and next line value.
   always_comb begin
      nxt_state_s   = state_r;
      nxt_cnt_s     = cnt_r;
      nxt_bit_idx_s = bit_idx_r;
      nxt_shift_s   = shift_r;
      nxt_tx_s      = tx_r;
      case (state_r)
         BIT_IDLE: begin
            if (start) begin
               nxt_state_s   = BIT_START;
               nxt_cnt_s     = 16'd0;
               nxt_bit_idx_s = 3'd0;
               nxt_shift_s   = data;
               nxt_tx_s      = 1'b0;
            end else begin
               nxt_cnt_s = 16'd0;
               nxt_tx_s  = 1'b1;
            end
         end
         BIT_START: begin
            if (bit_end_s) begin
               nxt_state_s   = BIT_DATA;
               nxt_cnt_s     = 16'd0;
               nxt_bit_idx_s = 3'd0;
               nxt_tx_s      = shift_r[0];
            end else begin
               nxt_cnt_s = 16'(cnt_r + 16'd1);
            end
         end
         BIT_DATA: begin
            if (bit_end_s) begin
               nxt_cnt_s = 16'd0;
               if (bit_idx_r == 3'd7) begin
                  nxt_state_s = BIT_STOP;
                  nxt_tx_s    = 1'b1;
               end else begin
                  nxt_bit_idx_s = 3'(bit_idx_r + 3'd1);
                  nxt_shift_s   = {1'b0, shift_r[7:1]};
                  nxt_tx_s      = shift_r[1];
               end
            end else begin
               nxt_cnt_s = 16'(cnt_r + 16'd1);
            end
         end
         BIT_STOP: begin
            if (bit_end_s) begin
               if (start) begin
                  nxt_state_s   = BIT_START;
                  nxt_cnt_s     = 16'd0;
                  nxt_bit_idx_s = 3'd0;
                  nxt_shift_s   = data;
                  nxt_tx_s      = 1'b0;
               end else begin
                  nxt_state_s = BIT_IDLE;
                  nxt_cnt_s   = 16'd0;
                  nxt_tx_s    = 1'b1;
               end
            end else begin
               nxt_cnt_s = 16'(cnt_r + 16'd1);
            end
         end
         default: begin
            nxt_state_s = BIT_IDLE;
            nxt_cnt_s   = 16'd0;
            nxt_tx_s    = 1'b1;
         end
      endcase
      // Registered done lands exactly on the final stop-bit cycle.
      nxt_done_s = (nxt_state_s == BIT_STOP) && (nxt_cnt_s == LAST_CNT);
   end

   // Bit-level state, counters and registered line outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= BIT_IDLE;
         cnt_r     <= 16'd0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'd0;
         tx_r      <= 1'b1;
         done_r    <= 1'b0;
      end else begin
         state_r   <= nxt_state_s;
         cnt_r     <= nxt_cnt_s;
         bit_idx_r <= nxt_bit_idx_s;
         shift_r   <= nxt_shift_s;
         tx_r      <= nxt_tx_s;
         done_r    <= nxt_done_s;
      end
   end

   assign tx   = tx_r;
   assign done = done_r;

endmodule

// File: rtl/frame_uart_tx.sv
// Captures a demodulated frame on finish, acknowledges with clear, and streams a 14-byte
// UART frame (header, status, payload) back-to-back through uart_tx_byte.
module frame_uart_tx #(
   parameter int CLKS_PER_BIT = 234,
   parameter int SEND_FAILED  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        finish,
   input  logic        success,
   input  logic [95:0] res,
   output logic        clear,
   output logic        tx,
   output logic        busy
);
   import frame_uart_tx_pkg::*;

   localparam logic SEND_NG = 1'(SEND_FAILED != 0);

   frame_state_t state_r, nxt_state_s;
   logic [3:0]   byte_idx_r, nxt_byte_idx_s, sel_idx_s;
   logic [95:0]  res_r;
   logic         success_r;
   logic         clear_r;
   logic         busy_r, nxt_busy_s;
   logic         capture_s;
   logic         start_s;
   logic         done_s;
   logic         byte_tx_s;
   logic [7:0]   byte_s;

   // Frame sequencing; the header is launched in the capture cycle so its start bit begins next cycle.
   always_comb begin
      nxt_state_s    = state_r;
      nxt_byte_idx_s = byte_idx_r;
      nxt_busy_s     = busy_r;
      capture_s      = 1'b0;
      start_s        = 1'b0;
      sel_idx_s      = 4'(byte_idx_r + 4'd1);
      case (state_r)
         ST_IDLE: begin
            sel_idx_s = 4'd0;
            if (finish) begin
               capture_s = 1'b1;
               if (SEND_NG || success) begin
                  nxt_state_s    = ST_SEND;
                  nxt_byte_idx_s = 4'd0;
                  nxt_busy_s     = 1'b1;
                  start_s        = 1'b1;
               end else begin
                  // Dropped frame still needs one settle cycle so the held finish is not re-captured.
                  nxt_state_s = ST_NEXT;
               end
            end else begin
               nxt_byte_idx_s = 4'd0;
            end
         end
         ST_SEND: begin
            if (done_s) begin
               if (byte_idx_r < LAST_BYTE_IDX) begin
                  nxt_byte_idx_s = 4'(byte_idx_r + 4'd1);
                  start_s        = 1'b1;
               end else begin
                  nxt_state_s = ST_NEXT;
                  nxt_busy_s  = 1'b0;
               end
            end else begin
               nxt_byte_idx_s = byte_idx_r;
            end
         end
         ST_NEXT: begin
            nxt_state_s    = ST_IDLE;
            nxt_byte_idx_s = 4'd0;
            nxt_busy_s     = 1'b0;
         end
         default: begin
            nxt_state_s    = ST_IDLE;
            nxt_byte_idx_s = 4'd0;
            nxt_busy_s     = 1'b0;
         end
      endcase
   end

   assign byte_s = frame_byte(sel_idx_s, success_r, res_r);

   // Frame state, byte index and capture registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         byte_idx_r <= 4'd0;
         res_r      <= 96'd0;
         success_r  <= 1'b0;
         clear_r    <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= nxt_state_s;
         byte_idx_r <= nxt_byte_idx_s;
         busy_r     <= nxt_busy_s;
         clear_r    <= capture_s;
         if (capture_s) begin
            res_r     <= res;
            success_r <= success;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk   (clk),
      .rst   (rst),
      .start (start_s),
      .data  (byte_s),
      .tx    (byte_tx_s),
      .done  (done_s)
   );

   assign clear = clear_r;
   assign tx    = byte_tx_s;
   assign busy  = busy_r;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Directed bench for frame_uart_tx: four instances cover CLKS_PER_BIT 4/2/234 and both SEND_FAILED settings.
module tb_frame_uart_tx;

   typedef logic [7:0] frame_t [14];

   logic        clk = 1'b0;
   logic        rst;
   logic        finish_a  [4];
   logic        success_a [4];
   logic [95:0] res_a     [4];
   logic        clear_a   [4];
   logic        tx_a      [4];
   logic        busy_a    [4];
   int          sel;
   int          total = 0;
   int          bad   = 0;
   int          err_n;
   frame_t      f1, f2, f3, f5;

   always #5 clk = ~clk;

   frame_uart_tx #(.CLKS_PER_BIT(4), .SEND_FAILED(1)) u_main (
      .clk(clk), .rst(rst), .finish(finish_a[0]), .success(success_a[0]), .res(res_a[0]),
      .clear(clear_a[0]), .tx(tx_a[0]), .busy(busy_a[0]));
   frame_uart_tx #(.CLKS_PER_BIT(4), .SEND_FAILED(0)) u_drop (
      .clk(clk), .rst(rst), .finish(finish_a[1]), .success(success_a[1]), .res(res_a[1]),
      .clear(clear_a[1]), .tx(tx_a[1]), .busy(busy_a[1]));
   frame_uart_tx #(.CLKS_PER_BIT(2), .SEND_FAILED(1)) u_fast (
      .clk(clk), .rst(rst), .finish(finish_a[2]), .success(success_a[2]), .res(res_a[2]),
      .clear(clear_a[2]), .tx(tx_a[2]), .busy(busy_a[2]));
   frame_uart_tx #(.CLKS_PER_BIT(234), .SEND_FAILED(1)) u_slow (
      .clk(clk), .rst(rst), .finish(finish_a[3]), .success(success_a[3]), .res(res_a[3]),
      .clear(clear_a[3]), .tx(tx_a[3]), .busy(busy_a[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Called on the negedge of the header start-bit cycle; returns on the negedge after the frame.
   task automatic check_frame(input string tag, input int cpb, input frame_t exp);
      int         cyc_err  = 0;
      int         busy_err = 0;
      int         clr_err  = 0;
      logic [9:0] word;
      logic [9:0] want;
      for (int b = 0; b < 14; b++) begin
         word = 10'd0;
         want = {1'b1, exp[b], 1'b0};
         for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < cpb; c++) begin
               if (!(b == 0 && k == 0 && c == 0)) begin
                  @(negedge clk);
                  if (clear_a[sel] !== 1'b0) clr_err++;
               end
               if (tx_a[sel] !== want[k]) cyc_err++;
               if (busy_a[sel] !== 1'b1) busy_err++;
               if (c == cpb / 2) word[k] = tx_a[sel];
            end
         end
         chk($sformatf("%s byte%0d", tag, b), 32'(word), 32'(want));
      end
      chk($sformatf("%s bit_cycles", tag), cyc_err, 0);
      chk($sformatf("%s busy_held", tag), busy_err, 0);
      chk($sformatf("%s no_extra_clear", tag), clr_err, 0);
      @(negedge clk);
      chk($sformatf("%s busy_fall", tag), 32'(busy_a[sel]), 32'd0);
      chk($sformatf("%s tx_idle", tag), 32'(tx_a[sel]), 32'd1);
   endtask

   initial begin
      f1 = '{8'hA5, 8'h01, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
             8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
      f2 = '{8'hA5, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
      f3 = '{8'hA5, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
             8'hCD, 8'hEF, 8'hFE, 8'hDC, 8'hBA, 8'h98};
      f5 = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      sel = 0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         finish_a[i]  = 1'b0;
         success_a[i] = 1'b0;
         res_a[i]     = 96'd0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst tx%0d", i), 32'(tx_a[i]), 32'd1);
         chk($sformatf("rst busy%0d", i), 32'(busy_a[i]), 32'd0);
         chk($sformatf("rst clear%0d", i), 32'(clear_a[i]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // All-0x55 payload with success
      finish_a[0] = 1'b1; success_a[0] = 1'b1; res_a[0] = {12{8'h55}};
      @(negedge clk);
      chk("f1 clear", 32'(clear_a[0]), 32'd1);
      chk("f1 busy", 32'(busy_a[0]), 32'd1);
      finish_a[0] = 1'b0;
      check_frame("f1", 4, f1);

      // finish raised on the cycle busy falls is taken one cycle later
      finish_a[0] = 1'b1; success_a[0] = 1'b0; res_a[0] = 96'h55_00000000000000000000_55;
      @(negedge clk);
      chk("f2 wait clear", 32'(clear_a[0]), 32'd0);
      chk("f2 wait tx", 32'(tx_a[0]), 32'd1);
      @(negedge clk);
      chk("f2 clear", 32'(clear_a[0]), 32'd1);
      finish_a[0] = 1'b0;
      check_frame("f2", 4, f2);

      // Second finish and new payload arrive 100 cycles into a frame
      finish_a[0] = 1'b1; success_a[0] = 1'b1; res_a[0] = 96'h0123456789ABCDEFFEDCBA98;
      repeat (2) @(negedge clk);
      chk("f3 clear", 32'(clear_a[0]), 32'd1);
      finish_a[0] = 1'b0;
      fork
         check_frame("f3", 4, f3);
         begin
            repeat (100) @(negedge clk);
            finish_a[0] = 1'b1; success_a[0] = 1'b0; res_a[0] = {12{8'h0F}};
         end
      join
      @(negedge clk);
      chk("f4 wait clear", 32'(clear_a[0]), 32'd0);
      @(negedge clk);
      chk("f4 clear", 32'(clear_a[0]), 32'd1);
      chk("f4 start", 32'(tx_a[0]), 32'd0);
      finish_a[0] = 1'b0;

      // Reset mid-frame at cycle 300, finish left high across the reset
      repeat (299) @(negedge clk);
      rst = 1'b1;
      finish_a[0] = 1'b1; success_a[0] = 1'b1; res_a[0] = 96'h800000000000000000000001;
      @(negedge clk);
      chk("abort tx", 32'(tx_a[0]), 32'd1);
      chk("abort busy", 32'(busy_a[0]), 32'd0);
      chk("abort clear", 32'(clear_a[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("f5 clear", 32'(clear_a[0]), 32'd1);
      finish_a[0] = 1'b0;
      check_frame("f5", 4, f5);

      // Failed frame dropped when SEND_FAILED=0
      sel = 1;
      finish_a[1] = 1'b1; success_a[1] = 1'b0; res_a[1] = 96'h55_00000000000000000000_55;
      @(negedge clk);
      chk("drop clear", 32'(clear_a[1]), 32'd1);
      chk("drop busy", 32'(busy_a[1]), 32'd0);
      chk("drop tx", 32'(tx_a[1]), 32'd1);
      finish_a[1] = 1'b0;
      err_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_a[1] !== 1'b1 || busy_a[1] !== 1'b0 || clear_a[1] !== 1'b0) err_n++;
      end
      chk("drop quiet", err_n, 0);
      finish_a[1] = 1'b1; success_a[1] = 1'b1; res_a[1] = {12{8'h55}};
      @(negedge clk);
      chk("drop ok clear", 32'(clear_a[1]), 32'd1);
      finish_a[1] = 1'b0;
      check_frame("drop ok", 4, f1);

      // Bit-width extremes
      sel = 2;
      finish_a[2] = 1'b1; success_a[2] = 1'b1; res_a[2] = 96'h0123456789ABCDEFFEDCBA98;
      @(negedge clk);
      chk("fast clear", 32'(clear_a[2]), 32'd1);
      finish_a[2] = 1'b0;
      check_frame("fast", 2, f3);

      sel = 3;
      finish_a[3] = 1'b1; success_a[3] = 1'b0; res_a[3] = 96'h55_00000000000000000000_55;
      @(negedge clk);
      chk("slow clear", 32'(clear_a[3]), 32'd1);
      finish_a[3] = 1'b0;
      check_frame("slow", 234, f2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
